crc8_frame_checker: RTL and testbench

Receive-side companion to the CRC-8 accumulator. It consumes a byte stream framed by a `last` marker, where the final byte of each frame is the transmitter's CRC-8. It recomputes the CRC over the whole frame, including the CRC byte, and reports per-frame pass/fail, length and residue. It also keeps saturating good/bad frame counters for the status readout.

---
 rtl/crc8_frame_checker_if.sv | 19 +
 rtl/crc8_frame_checker.sv | 187 ++++++++++++++++++
 tb/tb_crc8_frame_checker.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc8_frame_checker_if.sv
// Byte stream carrying CRC-terminated frames into the frame checker.
// The producer drives every field; the checker only listens (no backpressure).
interface crc8_frame_checker_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;

  modport master (
    output in_data,
    output in_valid,
    output in_last
  );

  modport slave (
    input in_data,
    input in_valid,
    input in_last
  );
endinterface

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 (poly 0x07, MSB-first) frame checker with per-frame
// result registers and saturating good/bad frame counters.
module crc8_frame_checker #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  crc8_frame_checker_if.slave     stream,
  input  logic                    clear_counts,
  output logic                    frame_done,
  output logic                    frame_ok,
  output logic [7:0]              frame_len,
  output logic [7:0]              crc_residue,
  output logic                    err_overlong,
  output logic                    busy,
  output logic [CNT_W-1:0]        good_count,
  output logic [CNT_W-1:0]        bad_count
);

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] crc;
  logic [7:0] crc_next;
  logic [7:0] len;
  logic [7:0] len_next;
  logic       overlong;
  logic       overlong_next;

  logic       end_frame;
  logic [7:0] end_crc;
  logic [7:0] end_len;
  logic       end_over;
  logic       end_ok;

  logic [7:0] crc_base;
  logic [7:0] crc_step;

  function automatic logic [7:0] crc_f(input logic [7:0] value);
    logic [7:0] c;
    c = value;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // A new frame always starts from a zero CRC, whatever the register holds.
  assign crc_base = (state == IDLE) ? 8'h00 : crc;
  assign crc_step = crc_f(crc_base ^ stream.in_data);

  always_comb begin
    state_next    = state;
    crc_next      = crc;
    len_next      = len;
    overlong_next = overlong;
    end_frame     = 1'b0;
    end_crc       = crc;
    end_len       = len;
    end_over      = overlong;

    case (state)
      IDLE: begin
        if (stream.in_valid) begin
          crc_next      = crc_step;
          len_next      = 8'd1;
          overlong_next = 1'b0;
          if (stream.in_last) begin
            end_frame = 1'b1;
            end_crc   = crc_step;
            end_len   = 8'd1;
            end_over  = 1'b0;
            crc_next  = 8'h00;
            len_next  = 8'd0;
          end else begin
            state_next = RECV;
          end
        end
      end

      RECV: begin
        if (stream.in_valid) begin
          if (len == MAX_LEN_B) begin
            // One byte past the limit: freeze CRC/length, flag overlong.
            overlong_next = 1'b1;
            if (stream.in_last) begin
              end_frame     = 1'b1;
              end_over      = 1'b1;
              state_next    = IDLE;
              crc_next      = 8'h00;
              len_next      = 8'd0;
              overlong_next = 1'b0;
            end else begin
              state_next = DROP;
            end
          end else if (stream.in_last) begin
            end_frame     = 1'b1;
            end_crc       = crc_step;
            end_len       = len + 8'd1;
            end_over      = 1'b0;
            state_next    = IDLE;
            crc_next      = 8'h00;
            len_next      = 8'd0;
            overlong_next = 1'b0;
          end else begin
            crc_next = crc_step;
            len_next = len + 8'd1;
          end
        end
      end

      DROP: begin
        if (stream.in_valid && stream.in_last) begin
          end_frame     = 1'b1;
          end_over      = 1'b1;
          state_next    = IDLE;
          crc_next      = 8'h00;
          len_next      = 8'd0;
          overlong_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign end_ok = (end_crc == 8'h00) && (end_len >= 8'd2) && !end_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      crc      <= 8'h00;
      len      <= 8'd0;
      overlong <= 1'b0;
    end else begin
      state    <= state_next;
      crc      <= crc_next;
      len      <= len_next;
      overlong <= overlong_next;
    end
  end

  // Result registers hold until the next frame end; clear beats counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_len    <= 8'd0;
      crc_residue  <= 8'h00;
      err_overlong <= 1'b0;
      good_count   <= '0;
      bad_count    <= '0;
    end else begin
      frame_done <= end_frame;
      if (end_frame) begin
        frame_ok     <= end_ok;
        frame_len    <= end_len;
        crc_residue  <= end_crc;
        err_overlong <= end_over;
      end
      if (clear_counts) begin
        good_count <= '0;
        bad_count  <= '0;
      end else if (end_frame) begin
        if (end_ok) begin
          if (good_count != CNT_MAX) good_count <= good_count + 1'b1;
        end else begin
          if (bad_count != CNT_MAX) bad_count <= bad_count + 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Scoreboard bench for crc8_frame_checker with MAX_LEN=16 and CNT_W=2 so the
// length limit and counter saturation are reached quickly.
module tb_crc8_frame_checker;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_counts;
  logic             frame_done;
  logic             frame_ok;
  logic [7:0]       frame_len;
  logic [7:0]       crc_residue;
  logic             err_overlong;
  logic             busy;
  logic [CNT_W-1:0] good_count;
  logic [CNT_W-1:0] bad_count;

  always #5 clk = ~clk;

  crc8_frame_checker_if stream ();

  crc8_frame_checker #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stream      (stream),
    .clear_counts(clear_counts),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_len   (frame_len),
    .crc_residue (crc_residue),
    .err_overlong(err_overlong),
    .busy        (busy),
    .good_count  (good_count),
    .bad_count   (bad_count)
  );

  typedef struct packed {
    logic             ok;
    logic [7:0]       len;
    logic [7:0]       res;
    logic             over;
    logic [CNT_W-1:0] good;
    logic [CNT_W-1:0] bad;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [CNT_W-1:0] model_good = '0;
  logic [CNT_W-1:0] model_bad  = '0;
  int               checks = 0;
  int               errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Bit-serial reference CRC over the first n bytes of a frame.
  function automatic logic [7:0] refCrc(input byte_q_t b, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (frame_done) begin
      checkOutput("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("frame_ok",     32'(frame_ok),     32'(mon_e.ok));
        checkOutput("frame_len",    32'(frame_len),    32'(mon_e.len));
        checkOutput("crc_residue",  32'(crc_residue),  32'(mon_e.res));
        checkOutput("err_overlong", 32'(err_overlong), 32'(mon_e.over));
        checkOutput("good_count",   32'(good_count),   32'(mon_e.good));
        checkOutput("bad_count",    32'(bad_count),    32'(mon_e.bad));
      end
    end
  end

  task automatic idle(input int cycles, input logic clr);
    stream.in_valid = 1'b0;
    stream.in_last  = 1'b0;
    stream.in_data  = 8'h00;
    clear_counts    = clr;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    clear_counts = 1'b0;
  endtask

  // Drives one frame; the expected result is pushed as the last byte goes out.
  task automatic applyStimulus(input byte_q_t b, input bit gaps, input bit clr);
    int         n;
    int         flen;
    logic       ov;
    logic [7:0] res;
    logic       ok;
    exp_t       e;
    n    = b.size();
    ov   = (n > MAX_LEN);
    flen = ov ? MAX_LEN : n;
    res  = refCrc(b, flen);
    ok   = (res == 8'h00) && (n >= 2) && !ov;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          stream.in_valid = 1'b0;
          stream.in_last  = 1'($urandom_range(0, 1));
          stream.in_data  = 8'($urandom);
          clear_counts    = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      stream.in_valid = 1'b1;
      stream.in_data  = b[k];
      stream.in_last  = (k == n - 1);
      clear_counts    = clr && (k == n - 1);
      if (k == n - 1) begin
        if (clr) begin
          model_good = '0;
          model_bad  = '0;
        end else if (ok) begin
          if (model_good != '1) model_good = model_good + 1'b1;
        end else begin
          if (model_bad != '1) model_bad = model_bad + 1'b1;
        end
        e.ok   = ok;
        e.len  = 8'(flen);
        e.res  = res;
        e.over = ov;
        e.good = model_good;
        e.bad  = model_bad;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (k == 0 && n > 1) checkOutput("busy_rise", 32'(busy), 32'd1);
      if (n == 1) checkOutput("short_busy", 32'(busy), 32'd0);
    end
    clear_counts = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_done"},    32'(frame_done),   32'd0);
    checkOutput({tag, "_ok"},      32'(frame_ok),     32'd0);
    checkOutput({tag, "_len"},     32'(frame_len),    32'd0);
    checkOutput({tag, "_residue"}, 32'(crc_residue),  32'd0);
    checkOutput({tag, "_overlong"},32'(err_overlong), 32'd0);
    checkOutput({tag, "_busy"},    32'(busy),         32'd0);
    checkOutput({tag, "_good"},    32'(good_count),   32'd0);
    checkOutput({tag, "_bad"},     32'(bad_count),    32'd0);
  endtask

  byte_q_t good_frame;
  byte_q_t bad_frame;
  byte_q_t zero_frame;
  byte_q_t short_frame;
  byte_q_t max_frame;
  byte_q_t long_frame;

  initial begin
    good_frame  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    bad_frame   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    zero_frame  = '{8'h00, 8'h00};
    short_frame = '{8'h00};
    max_frame   = {};
    for (int i = 0; i < MAX_LEN - 1; i++) max_frame.push_back(8'($urandom));
    max_frame.push_back(refCrc(max_frame, MAX_LEN - 1));
    long_frame = {};
    for (int i = 0; i < 20; i++) long_frame.push_back(8'($urandom));

    rst = 1'b1;
    idle(3, 1'b0);
    checkAllZero("reset");
    rst = 1'b0;
    idle(2, 1'b0);

    $display("[TB] known-good frame");
    applyStimulus(good_frame, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] corrupted frame followed back-to-back by a zero frame");
    applyStimulus(bad_frame, 1'b0, 1'b0);
    applyStimulus(zero_frame, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] single-byte frame");
    applyStimulus(short_frame, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] length boundary");
    applyStimulus(max_frame, 1'b0, 1'b0);
    applyStimulus(long_frame, 1'b0, 1'b0);
    applyStimulus(good_frame, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] gaps and mid-frame reset");
    applyStimulus(good_frame, 1'b1, 1'b0);
    idle(3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      stream.in_valid = 1'b1;
      stream.in_data  = good_frame[k];
      stream.in_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    idle(1, 1'b0);
    rst = 1'b0;
    model_good = '0;
    model_bad  = '0;
    checkAllZero("midreset");
    idle(3, 1'b0);
    checkOutput("midreset_quiet", 32'(frame_done), 32'd0);
    applyStimulus(good_frame, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("[TB] counter saturation and clear");
    idle(1, 1'b1);
    model_good = '0;
    model_bad  = '0;
    checkOutput("clear_good", 32'(good_count), 32'd0);
    checkOutput("clear_bad",  32'(bad_count),  32'd0);
    for (int f = 0; f < 5; f++) applyStimulus(good_frame, 1'b0, 1'b0);
    applyStimulus(bad_frame, 1'b0, 1'b0);
    applyStimulus(bad_frame, 1'b0, 1'b1);
    idle(3, 1'b0);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
